// File: rtl/clock_switch_ctrl_if.sv
// Request/response handshake between a clock-select requester and the
// clock switch control sequencer.
interface clock_switch_ctrl_if #(
  parameter int SEL_W = 2
);
  logic             req_valid;
  logic [SEL_W-1:0] req_sel;
  logic             req_ready;
  logic             rsp_valid;
  logic [1:0]       rsp_code;

  modport master (
    output req_valid, req_sel,
    input  req_ready, rsp_valid, rsp_code
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, rsp_valid, rsp_code
  );
endinterface

// File: rtl/clock_switch_ctrl.sv
// Control sequencer for the glitch-free clock switch: power-up ICG bypass,
// handshaked clock selection with settle time, and scan-mode entry.
module clock_switch_ctrl #(
  parameter int NUM_CLK    = 3,
  parameter int SEL_W      = 2,
  parameter int DEF_SEL    = 1,
  parameter int INIT_CYC   = 32,
  parameter int SETTLE_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_clk_n,
  clock_switch_ctrl_if.slave   bus,
  input  logic                 scan_req,
  output logic [SEL_W-1:0]     clk_sel,
  output logic                 dc_scan_mode,
  output logic                 icg_scan_mode,
  output logic                 busy
);

  localparam int CNT_MAX = (INIT_CYC > SETTLE_CYC) ? INIT_CYC : SETTLE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] INIT_LD   = CNT_W'(INIT_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [SEL_W:0]   NUM_CLK_W = (SEL_W + 1)'(NUM_CLK);
  localparam logic [SEL_W-1:0] DEF_SEL_W = SEL_W'(DEF_SEL);

  localparam logic [1:0] RSP_OK    = 2'b00;
  localparam logic [1:0] RSP_ILLEG = 2'b01;
  localparam logic [1:0] RSP_NOOP  = 2'b10;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SETTLE,
    S_RESP,
    S_SCAN
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [1:0]       code_nxt;
  logic             ready_d, rsp_valid_d, dc_d, icg_d, busy_d;

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values; the synchronous reset also covers every output register.
  always_ff @(posedge clk) begin
    if (!rst_clk_n) begin
      state         <= S_INIT;
      cnt           <= INIT_LD;
      clk_sel       <= DEF_SEL_W;
      bus.rsp_code  <= RSP_OK;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      dc_scan_mode  <= 1'b0;
      icg_scan_mode <= 1'b1;
      busy          <= 1'b1;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      clk_sel       <= sel_nxt;
      bus.rsp_code  <= code_nxt;
      bus.req_ready <= ready_d;
      bus.rsp_valid <= rsp_valid_d;
      dc_scan_mode  <= dc_d;
      icg_scan_mode <= icg_d;
      busy          <= busy_d;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = clk_sel;
    code_nxt  = bus.rsp_code;
    unique case (state)
      S_INIT: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      S_IDLE: begin
        // Scan entry outranks a concurrent request, which stays pending.
        if (scan_req) begin
          state_nxt = S_SCAN;
        end else if (bus.req_valid) begin
          if ({1'b0, bus.req_sel} >= NUM_CLK_W) begin
            code_nxt  = RSP_ILLEG;
            state_nxt = S_RESP;
          end else if (bus.req_sel == clk_sel) begin
            code_nxt  = RSP_NOOP;
            state_nxt = S_RESP;
          end else begin
            sel_nxt   = bus.req_sel;
            cnt_nxt   = SETTLE_LD;
            state_nxt = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (cnt == '0) begin
          code_nxt  = RSP_OK;
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      S_SCAN:  if (!scan_req) state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  // Outputs are decoded from the next state so they land in registers.
  always_comb begin
    ready_d     = (state_nxt == S_IDLE);
    busy_d      = (state_nxt != S_IDLE);
    rsp_valid_d = (state_nxt == S_RESP);
    dc_d        = (state_nxt == S_SCAN);
    icg_d       = (state_nxt == S_INIT);
  end

endmodule
